uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver. The serial input is synchronised through
//                two flops, the start bit is confirmed at its midpoint, and
//                data and stop bits are then sampled once per bit period at
//                mid-bit.
//
//  Ports       : clk          system clock, rising-edge
//                reset        synchronous active-high reset
//                rx           asynchronous serial line, idle high
//                rx_data      last correctly received byte
//                rx_valid     one-cycle pulse, rx_data just updated
//                frame_error  one-cycle pulse, stop bit sampled low
//                busy         high while the receiver is not idle
//
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);

    // Terminal counts: mid start bit, then one full bit period per sample.
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_stop      = 3'd3;
    localparam logic [2:0] c_st_wait_high = 3'd4;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_error;

    // Two-flop synchroniser; both flops reset to the idle line level so a
    // reset never manufactures a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                    if (!r_rx_s) begin
                        r_state <= c_st_start;
                    end
                end

                // A line that is high again at mid start bit was a glitch.
                c_st_start: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? c_st_idle : c_st_data;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // LSB arrives first, so shift right and insert at bit 7.
                c_st_data: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= c_st_stop;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // Leaving at mid stop bit leaves half a bit of margin to
                // catch a back-to-back start bit.
                c_st_stop: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_state    <= c_st_idle;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= c_st_wait_high;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A break holds the line low; wait it out so it reports once.
                c_st_wait_high: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;
    assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. A fast instance
//                (8 clocks/bit) covers the directed cases; a slow instance
//                (434 clocks/bit) covers back-to-back frames at the nominal
//                rate. Expected bytes are queued as frames are driven and
//                popped as rx_valid pulses appear.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_cpb      = 8;
    localparam int c_cpb_slow = 434;
    localparam int c_lat      = c_cpb / 2 + 9 * c_cpb + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rx2;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;
    logic [7:0] rx_data2;
    logic       rx_valid2;
    logic       frame_error2;
    logic       busy2;

    always #10 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(c_cpb)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    uart_rx #(.CLKS_PER_BIT(c_cpb_slow)) u_dut_slow (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx2),
        .rx_data     (rx_data2),
        .rx_valid    (rx_valid2),
        .frame_error (frame_error2),
        .busy        (busy2)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [7:0] q_fast[$];
    logic [7:0] q_slow[$];
    int         t_slow[$];
    int         n_valid     = 0;
    int         n_ferr      = 0;
    int         n_both      = 0;
    int         n_ferr_s    = 0;
    int         n_push_fast = 0;
    int         t_valid     = 0;
    int         t_fall      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one 8N1 frame on the fast or slow line, one bit per bit period.
    task automatic send(input bit slow, input logic [7:0] data, input logic stop, input bit expect_it);
        int         n;
        logic [9:0] frame;
        n     = slow ? c_cpb_slow : c_cpb;
        frame = {stop, data, 1'b0};
        if (expect_it) begin
            if (slow) begin
                q_slow.push_back(data);
            end else begin
                q_fast.push_back(data);
                n_push_fast++;
            end
        end
        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            if (b == 0) t_fall = cyc;
            if (slow) rx2 = frame[b];
            else      rx  = frame[b];
            repeat (n - 1) @(negedge clk);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (rx_valid) begin
            n_valid++;
            t_valid = cyc;
            check("fast_valid_expected", 32'(q_fast.size() > 0), 1);
            if (q_fast.size() > 0) check("fast_rx_data", rx_data, q_fast.pop_front());
        end
        if (frame_error) n_ferr++;
        if (rx_valid && frame_error) n_both++;
        if (rx_valid2) begin
            t_slow.push_back(cyc);
            check("slow_valid_expected", 32'(q_slow.size() > 0), 1);
            if (q_slow.size() > 0) check("slow_rx_data", rx_data2, q_slow.pop_front());
        end
        if (frame_error2) n_ferr_s++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv0;
        int nf0;
        int lat;
        int k;
        bit seen;

        reset = 1'b1;
        rx    = 1'b1;
        rx2   = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_rx_data",     rx_data,     8'h00);
        check("reset_rx_valid",    rx_valid,    0);
        check("reset_frame_error", frame_error, 0);
        check("reset_busy",        busy,        0);
        check("reset_busy_slow",   busy2,       0);
        reset = 1'b0;
        repeat (3 * c_cpb) @(negedge clk);

        // Single frame 0x55 with latency measurement.
        nv0 = n_valid;
        send(0, 8'h55, 1'b1, 1);
        repeat (c_cpb) @(negedge clk);
        check("x55_one_valid", n_valid - nv0, 1);
        lat = t_valid - t_fall - 2;
        check("x55_latency", (lat >= c_lat - 1 && lat <= c_lat + 1) ? c_lat : lat, c_lat);
        check("x55_no_ferr", n_ferr, 0);

        // Short low glitch must be rejected.
        nv0  = n_valid;
        nf0  = n_ferr;
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        k    = 0;
        while (k < 4 * c_cpb) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) break;
            k++;
        end
        check("glitch_busy_seen", seen, 1);
        check("glitch_busy_clear", 32'(k <= c_cpb), 1);
        repeat (2 * c_cpb) @(negedge clk);
        check("glitch_no_valid", n_valid - nv0, 0);
        check("glitch_no_ferr",  n_ferr - nf0,  0);

        // Bad stop bit followed by a long break, then a good frame.
        nf0 = n_ferr;
        send(0, 8'h0F, 1'b0, 0);
        repeat (20 * c_cpb) @(negedge clk);
        check("break_one_ferr",   n_ferr - nf0, 1);
        check("break_data_holds", rx_data,      8'h55);
        check("break_busy",       busy,         1);
        rx = 1'b1;
        repeat (2 * c_cpb) @(negedge clk);
        nv0 = n_valid;
        send(0, 8'h81, 1'b1, 1);
        repeat (c_cpb) @(negedge clk);
        check("after_break_valid", n_valid - nv0, 1);
        check("after_break_ferr",  n_ferr - nf0,  1);

        // Reset pulse during data bit 4 aborts the frame silently.
        nv0 = n_valid;
        nf0 = n_ferr;
        fork
            send(0, 8'hF0, 1'b1, 0);
            begin
                repeat (c_cpb + 4 * c_cpb + 3) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join
        repeat (2 * c_cpb) @(negedge clk);
        check("abort_rx_data", rx_data,       8'h00);
        check("abort_busy",    busy,          0);
        check("abort_valid",   n_valid - nv0, 0);
        check("abort_ferr",    n_ferr - nf0,  0);
        send(0, 8'hC3, 1'b1, 1);
        repeat (c_cpb) @(negedge clk);
        check("c3_one_valid", n_valid - nv0, 1);

        // Nominal-rate back-to-back frames.
        send(1, 8'hA5, 1'b1, 1);
        send(1, 8'h3C, 1'b1, 1);
        repeat (c_cpb_slow) @(negedge clk);
        check("slow_two_valids", t_slow.size(), 2);
        if (t_slow.size() == 2) begin
            lat = t_slow[1] - t_slow[0];
            check("slow_spacing",
                  (lat >= 10 * c_cpb_slow - 1 && lat <= 10 * c_cpb_slow + 1) ? 10 * c_cpb_slow : lat,
                  10 * c_cpb_slow);
        end

        // Transmitter stream: back-to-back random bytes.
        for (int i = 0; i < 6; i++) begin
            send(0, 8'($urandom_range(0, 255)), 1'b1, 1);
        end
        repeat (2 * c_cpb) @(negedge clk);

        check("fast_queue_empty",  q_fast.size(), 0);
        check("slow_queue_empty",  q_slow.size(), 0);
        check("fast_valid_count",  n_valid,       n_push_fast);
        check("fast_ferr_total",   n_ferr,        1);
        check("valid_ferr_overlap", n_both,       0);
        check("slow_ferr_total",   n_ferr_s,      0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
